// File: rtl/ball_step_sequencer.sv
// ball_step_sequencer
//   Per-frame scheduler for the BallMaze ball physics. On each accepted frame
//   tick it strobes the acceleration stage, then the velocity stage, then walks
//   the ball one pixel at a time (all X steps, then all Y steps). Each pixel is
//   checked against the maze map through a req/ack wall lookup. Owns the ball
//   position and latches arrival at the goal cell.
//
//   clk108MHz    system clock
//   resetPressed synchronous active-high reset
//   run          1 = frame ticks start updates
//   xVelocity    signed pixels/frame, x
//   yVelocity    signed pixels/frame, y (+ = down)
//   accelStep    1-cycle strobe to the acceleration stage
//   velStep      1-cycle strobe to the velocity stage
//   wallReq      wall lookup request for (wallCol, wallRow)
//   wallCol/Row  candidate pixel, stable while wallReq=1
//   wallAck      lookup done, wallHit valid this cycle
//   wallHit      1 = candidate pixel is wall
//   ballColumn   current ball column
//   ballRow      current ball row
//   bumpX/bumpY  1-cycle pulse: motion on that axis blocked this frame
//   busy         frame update in progress
//   overrun      sticky: tick arrived while busy
//   goalReached  ball sits on the goal cell (terminal)
module ball_step_sequencer #(
    parameter int TICK_CYCLES  = 1350000,
    parameter int START_X      = 128,
    parameter int START_Y      = 188,
    parameter int GOAL_X       = 240,
    parameter int GOAL_Y       = 8,
    parameter int DP_LATENCY   = 2,
    parameter int WALL_TIMEOUT = 15
) (
    input  logic       clk108MHz,
    input  logic       resetPressed,
    input  logic       run,
    input  logic [4:0] xVelocity,
    input  logic [4:0] yVelocity,
    output logic       accelStep,
    output logic       velStep,
    output logic       wallReq,
    output logic [7:0] wallCol,
    output logic [7:0] wallRow,
    input  logic       wallAck,
    input  logic       wallHit,
    output logic [7:0] ballColumn,
    output logic [7:0] ballRow,
    output logic       bumpX,
    output logic       bumpY,
    output logic       busy,
    output logic       overrun,
    output logic       goalReached
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DP_LATENCY + 1);
    localparam int WW = $clog2(WALL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, ACCEL, WAIT_A, VEL, WAIT_V, LOAD, X_REQ, Y_REQ, GOAL, WON
    } seqState;

    seqState        state;
    logic [TW-1:0]  tickCount;
    logic           tick;
    logic [DW-1:0]  dpCount;
    logic [WW-1:0]  waitCount;
    logic [5:0]     stepsX, stepsY;
    logic           dirX, dirY;       // 1 = toward smaller coordinate

    // Shared view of whichever axis is currently being walked.
    logic           onY;
    logic [7:0]     pos, cand;
    logic           dir;
    logic [5:0]     steps;
    logic           edgeBlock;

    // 6-bit magnitude so that -16 yields 16.
    function automatic logic [5:0] magnitude(input logic [4:0] v);
        logic [5:0] ext;
        ext = {v[4], v};
        return v[4] ? (~ext + 6'd1) : ext;
    endfunction

    assign tick = (tickCount == TW'(TICK_CYCLES - 1));
    assign busy = (state != IDLE) && (state != WON);

    always_comb begin
        onY       = (state == Y_REQ);
        pos       = onY ? ballRow : ballColumn;
        dir       = onY ? dirY : dirX;
        steps     = onY ? stepsY : stepsX;
        cand      = dir ? pos - 8'd1 : pos + 8'd1;
        // Stepping off the 8-bit field is treated as a wall, no lookup issued.
        edgeBlock = dir ? (pos == 8'd0) : (pos == 8'd255);
    end

    always_ff @(posedge clk108MHz) begin
        if (resetPressed) begin
            tickCount   <= '0;
            state       <= IDLE;
            ballColumn  <= 8'(START_X);
            ballRow     <= 8'(START_Y);
            accelStep   <= 1'b0;
            velStep     <= 1'b0;
            wallReq     <= 1'b0;
            wallCol     <= '0;
            wallRow     <= '0;
            bumpX       <= 1'b0;
            bumpY       <= 1'b0;
            overrun     <= 1'b0;
            goalReached <= 1'b0;
            dpCount     <= '0;
            waitCount   <= '0;
            stepsX      <= '0;
            stepsY      <= '0;
            dirX        <= 1'b0;
            dirY        <= 1'b0;
        end else begin
            tickCount <= tick ? '0 : tickCount + 1'b1;
            accelStep <= 1'b0;
            velStep   <= 1'b0;
            bumpX     <= 1'b0;
            bumpY     <= 1'b0;

            if (tick && run && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: if (tick && run) begin
                    state     <= ACCEL;
                    accelStep <= 1'b1;
                end
                ACCEL: begin
                    state   <= WAIT_A;
                    dpCount <= '0;
                end
                WAIT_A: if (dpCount == DW'(DP_LATENCY - 1)) begin
                    state   <= VEL;
                    velStep <= 1'b1;
                end else begin
                    dpCount <= dpCount + 1'b1;
                end
                VEL: begin
                    state   <= WAIT_V;
                    dpCount <= '0;
                end
                WAIT_V: if (dpCount == DW'(DP_LATENCY - 1))
                    state <= LOAD;
                else
                    dpCount <= dpCount + 1'b1;
                LOAD: begin
                    stepsX <= magnitude(xVelocity);
                    dirX   <= xVelocity[4];
                    stepsY <= magnitude(yVelocity);
                    dirY   <= yVelocity[4];
                    state  <= X_REQ;
                end
                X_REQ, Y_REQ: begin
                    if (wallReq) begin
                        // Ack wins over a timeout landing in the same cycle.
                        if (wallAck && !wallHit) begin
                            wallReq <= 1'b0;
                            if (onY) begin
                                ballRow <= cand;
                                stepsY  <= stepsY - 6'd1;
                            end else begin
                                ballColumn <= cand;
                                stepsX     <= stepsX - 6'd1;
                            end
                        end else if (wallAck || waitCount == WW'(WALL_TIMEOUT - 1)) begin
                            wallReq <= 1'b0;
                            if (onY) begin
                                bumpY  <= 1'b1;
                                stepsY <= '0;
                                state  <= GOAL;
                            end else begin
                                bumpX  <= 1'b1;
                                stepsX <= '0;
                                state  <= Y_REQ;
                            end
                        end else begin
                            waitCount <= waitCount + 1'b1;
                        end
                    end else if (steps == 6'd0) begin
                        state <= onY ? GOAL : Y_REQ;
                    end else if (edgeBlock) begin
                        if (onY) begin
                            bumpY  <= 1'b1;
                            stepsY <= '0;
                            state  <= GOAL;
                        end else begin
                            bumpX  <= 1'b1;
                            stepsX <= '0;
                            state  <= Y_REQ;
                        end
                    end else begin
                        // Reached only with wallReq low, so every request is
                        // preceded by at least one idle cycle.
                        wallReq   <= 1'b1;
                        waitCount <= '0;
                        wallCol   <= onY ? ballColumn : cand;
                        wallRow   <= onY ? cand : ballRow;
                    end
                end
                GOAL: if (ballColumn == 8'(GOAL_X) && ballRow == 8'(GOAL_Y)) begin
                    state       <= WON;
                    goalReached <= 1'b1;
                end else begin
                    state <= IDLE;
                end
                WON: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_step_sequencer.sv
// Bench for ball_step_sequencer: directed scenarios plus randomized frames,
// each frame predicted by a pixel-walk reference model (list of expected
// lookups, final position, bumps, goal).
module tb_ball_step_sequencer;
    localparam int TICK = 256;
    localparam int DPL  = 2;
    localparam int WTO  = 15;
    localparam int SX   = 128;
    localparam int SY   = 188;
    localparam int GX   = 240;
    localparam int GY   = 8;

    logic       clk108MHz    = 1'b0;
    logic       resetPressed = 1'b1;
    logic       run          = 1'b0;
    logic [4:0] xVelocity    = '0;
    logic [4:0] yVelocity    = '0;
    logic       wallAck;
    logic       wallHit;
    logic       accelStep, velStep, wallReq;
    logic [7:0] wallCol, wallRow, ballColumn, ballRow;
    logic       bumpX, bumpY, busy, overrun, goalReached;

    ball_step_sequencer #(
        .TICK_CYCLES(TICK), .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY),
        .DP_LATENCY(DPL), .WALL_TIMEOUT(WTO)
    ) dut (
        .clk108MHz(clk108MHz), .resetPressed(resetPressed), .run(run),
        .xVelocity(xVelocity), .yVelocity(yVelocity),
        .accelStep(accelStep), .velStep(velStep),
        .wallReq(wallReq), .wallCol(wallCol), .wallRow(wallRow),
        .wallAck(wallAck), .wallHit(wallHit),
        .ballColumn(ballColumn), .ballRow(ballRow),
        .bumpX(bumpX), .bumpY(bumpY), .busy(busy),
        .overrun(overrun), .goalReached(goalReached)
    );

    always #5 clk108MHz = ~clk108MHz;

    int passCnt = 0, totalCnt = 0, failCnt = 0;

    // Reference model state
    int mx = SX, my = SY;
    int expReq[$];
    bit expWon = 0, expOvr = 0;

    // Environment
    int ackDelay = 0, wallColumn = -1, wallRowLine = -1;

    // Observations (each written by one process only)
    int obsQ[$], lenQ[$];
    int stableErr = 0, respAge = 0;
    int bxCnt = 0, byCnt = 0;
    logic [7:0] c0, r0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) begin
            passCnt++;
        end else begin
            failCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit isWall(input int c, input int r);
        return (c == wallColumn) || (r == wallRowLine);
    endfunction

    function automatic int clamp15(input int v);
        return (v > 15) ? 15 : ((v < -15) ? -15 : v);
    endfunction

    // Walk the ball pixel by pixel: X first, then Y; any wall, edge or
    // unanswered lookup stops that axis for the frame.
    task automatic modelFrame(input int vx, input int vy, input int d,
                              output int ebx, output int eby);
        bit tout;
        int c;
        tout = (d >= WTO);
        ebx = 0; eby = 0;
        expReq.delete();
        for (int i = 0; i < (vx < 0 ? -vx : vx); i++) begin
            c = mx + (vx < 0 ? -1 : 1);
            if (c < 0 || c > 255) begin ebx = 1; break; end
            expReq.push_back(c * 256 + my);
            if (tout || isWall(c, my)) begin ebx = 1; break; end
            mx = c;
        end
        for (int i = 0; i < (vy < 0 ? -vy : vy); i++) begin
            c = my + (vy < 0 ? -1 : 1);
            if (c < 0 || c > 255) begin eby = 1; break; end
            expReq.push_back(mx * 256 + c);
            if (tout || isWall(mx, c)) begin eby = 1; break; end
            my = c;
        end
    endtask

    // Wall map responder: acks after ackDelay extra cycles, records each
    // request's address and length, flags address changes mid-request.
    initial begin
        wallAck = 1'b0;
        wallHit = 1'b0;
        forever begin
            @(negedge clk108MHz);
            wallAck = 1'b0;
            wallHit = 1'b0;
            if (wallReq === 1'b1) begin
                respAge++;
                if (respAge == 1) begin
                    c0 = wallCol; r0 = wallRow;
                    obsQ.push_back(int'(wallCol) * 256 + int'(wallRow));
                end else if (wallCol !== c0 || wallRow !== r0) begin
                    stableErr++;
                end
                if (respAge > ackDelay) begin
                    wallAck = 1'b1;
                    wallHit = isWall(int'(wallCol), int'(wallRow));
                end
            end else if (respAge != 0) begin
                lenQ.push_back(respAge);
                respAge = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk108MHz);
            if (bumpX === 1'b1) bxCnt++;
            if (bumpY === 1'b1) byCnt++;
        end
    end

    task automatic doReset();
        @(negedge clk108MHz);
        resetPressed = 1'b1;
        run = 1'b0;
        @(negedge clk108MHz);
        resetPressed = 1'b0;
        mx = SX; my = SY;
        expWon = 0; expOvr = 0;
    endtask

    task automatic doFrame(input int vx, input int vy, input int d, input bit keepRun,
                           output int waited);
        int ebx, eby, base, bx0, by0, se0, nObs, g, expLen;
        modelFrame(vx, vy, d, ebx, eby);
        if (mx == GX && my == GY) expWon = 1;
        expLen = (d >= WTO) ? WTO : d + 1;
        ackDelay = d;
        base = obsQ.size(); bx0 = bxCnt; by0 = byCnt; se0 = stableErr;
        xVelocity = 5'(vx);
        yVelocity = 5'(vy);
        run = 1'b1;
        waited = 0;
        while (accelStep !== 1'b1 && waited <= TICK + 4) begin
            @(negedge clk108MHz);
            waited++;
        end
        if (accelStep !== 1'b1) begin
            chk("tick_accept", accelStep, 1);
            run = 1'b0;
            return;
        end
        if (!keepRun) run = 1'b0;
        @(negedge clk108MHz);
        chk("accel_pulse", accelStep, 0);
        repeat (DPL) @(negedge clk108MHz);
        chk("vel_strobe", velStep, 1);
        @(negedge clk108MHz);
        chk("vel_pulse", velStep, 0);
        // Velocity already latched by now; later changes must not matter.
        repeat (DPL + 1) @(negedge clk108MHz);
        xVelocity = 5'($urandom);
        yVelocity = 5'($urandom);
        g = 0;
        while (busy !== 1'b0 && g < 3000) begin
            @(negedge clk108MHz);
            g++;
        end
        run = 1'b0;
        chk("busy_done", busy, 0);
        chk("ball_col", ballColumn, mx);
        chk("ball_row", ballRow, my);
        chk("bumpx_pulses", bxCnt - bx0, ebx);
        chk("bumpy_pulses", byCnt - by0, eby);
        chk("goal", goalReached, expWon);
        chk("overrun", overrun, expOvr);
        chk("req_stable", stableErr - se0, 0);
        nObs = obsQ.size() - base;
        chk("req_count", nObs, expReq.size());
        for (int i = 0; i < nObs && i < expReq.size(); i++) begin
            chk("req_addr", obsQ[base + i], expReq[i]);
            chk("req_len", lenQ[base + i], expLen);
        end
    endtask

    initial begin
        int waited, g, act;
        doReset();
        chk("rst_col", ballColumn, SX);
        chk("rst_row", ballRow, SY);
        chk("rst_wallreq", wallReq, 0);
        chk("rst_accel", accelStep, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_goal", goalReached, 0);

        // Plain +3 move, also checks first tick position after reset
        doFrame(3, 0, 0, 1'b0, waited);
        chk("first_tick_latency", waited, TICK);
        chk("t1_col", ballColumn, 131);
        chk("t1_row", ballRow, 188);

        // Wall at column 120 stops a -16 move at 121, Y still runs
        wallColumn = 120;
        doFrame(-16, -5, 1, 1'b0, waited);
        chk("t2_col", ballColumn, 121);
        wallColumn = -1;

        // Randomized frames with random walls and ack latency
        for (int f = 0; f < 6; f++) begin
            wallColumn  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1;
            wallRowLine = ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 255)) : -1;
            doFrame(int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
                    int'($urandom_range(0, 3)), 1'b0, waited);
        end
        wallColumn = -1;
        wallRowLine = -1;

        // Right edge: land on 254, then +5 stops at 255 with no lookup of 256
        g = 0;
        while (mx < 240 && g < 30) begin
            doFrame(15, 0, int'($urandom_range(0, 3)), 1'b0, waited);
            g++;
        end
        doFrame(254 - mx, 0, 0, 1'b0, waited);
        chk("t3_col254", ballColumn, 254);
        doFrame(5, 0, 0, 1'b0, waited);
        chk("t3_col255", ballColumn, 255);

        // No ack ever: each lookup times out after WTO cycles and blocks
        doFrame(-2, 1, 100, 1'b0, waited);
        chk("t4_col", ballColumn, 255);

        // Slow acks at the timeout boundary, run held high: overrun
        expOvr = 1;
        doFrame(-15, (my >= 128) ? -15 : 15, WTO - 1, 1'b1, waited);
        chk("t5_overrun", overrun, 1);
        chk("t5_col", ballColumn, 240);

        // Walk to (239,8), then step into the goal
        doReset();
        chk("rst2_overrun", overrun, 0);
        chk("rst2_col", ballColumn, SX);
        g = 0;
        while ((mx != GX - 1 || my != GY) && g < 20) begin
            doFrame(clamp15(GX - 1 - mx), clamp15(GY - my), 0, 1'b0, waited);
            g++;
        end
        doFrame(1, 0, 0, 1'b0, waited);
        chk("t6_goal", goalReached, 1);

        run = 1'b1;
        act = 0;
        repeat (2 * TICK + 4) begin
            @(negedge clk108MHz);
            if (accelStep === 1'b1 || velStep === 1'b1 || wallReq === 1'b1 || busy === 1'b1)
                act++;
        end
        run = 1'b0;
        chk("won_quiet", act, 0);
        chk("won_overrun", overrun, 0);
        chk("won_goal_hold", goalReached, 1);

        // Reset while a lookup is outstanding
        doReset();
        chk("rst3_goal", goalReached, 0);
        ackDelay = 10;
        xVelocity = 5'd5;
        yVelocity = 5'd0;
        run = 1'b1;
        g = 0;
        while (wallReq !== 1'b1 && g < 400) begin
            @(negedge clk108MHz);
            g++;
        end
        run = 1'b0;
        chk("mid_req_seen", wallReq, 1);
        resetPressed = 1'b1;
        @(negedge clk108MHz);
        resetPressed = 1'b0;
        chk("abort_wallreq", wallReq, 0);
        chk("abort_col", ballColumn, SX);
        chk("abort_row", ballRow, SY);
        chk("abort_busy", busy, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 passCnt, totalCnt);
        $fatal(1, "watchdog");
    end

endmodule
